// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode definitions: reset vector, opcodes, fetch FSM states
// and the branch/jump target arithmetic also used by decoder-side code.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam int          MAX_OUT_DEF  = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] instr);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        return pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, instr} pairs between instruction memory and the decoder.
// Flush empties it in one cycle; depth equals the fetch credit limit, so it cannot overflow.
module fetch_buf
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_eff = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_q[gi] <= '0;
                end else if (push_i && !flush_i && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_eff) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
        end
    end

    // The fetch credit rule guarantees this; a hit means the credit logic is broken.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push_i && !flush_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads, buffers returns
// and redirects on decoder branch/jump, discarding responses already in flight.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          MAX_OUT  = MAX_OUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        dobranch,
    input  logic        dojump
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    fetch_entry_t     buf_head;
    fetch_entry_t     buf_push_data;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    logic             buf_push;
    logic             buf_pop;

    logic [CNT_W:0]   inflight_sum;
    logic             accept;
    logic             taken;
    logic [31:0]      target;

    fetch_buf #(
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (buf_push),
        .push_data_i (buf_push_data),
        .pop_i       (buf_pop),
        .flush_i     (taken),
        .head_o      (buf_head),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    // Credits cover both words in flight and words waiting in the buffer.
    assign inflight_sum = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign imem_req     = (state_q == S_RUN) && (inflight_sum < (CNT_W + 1)'(MAX_OUT));
    assign imem_addr    = fetch_pc_q;
    assign accept       = imem_req && imem_ready;

    assign instr_valid  = !buf_empty;
    assign instr        = instr_valid ? buf_head.instr : 32'd0;
    assign instr_pc     = instr_valid ? buf_head.pc    : 32'd0;
    assign buf_pop      = instr_valid && instr_ready;
    assign taken        = buf_pop && (dobranch || dojump);
    assign target       = dojump ? jump_target(buf_head.pc, buf_head.instr)
                                 : branch_target(buf_head.pc, buf_head.instr);

    // Returned words pair with the pc of the oldest request; in-flight pcs trail fetch_pc.
    assign buf_push           = imem_rvalid && (discard_q == '0) && !taken;
    assign buf_push_data.pc   = fetch_pc_q - {outstanding_q, 2'b00};
    assign buf_push_data.instr = imem_rdata;

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        discard_d     = discard_q;
        fetch_pc_d    = fetch_pc_q;
        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (taken) begin
            discard_d  = outstanding_d;
            fetch_pc_d = target;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (taken && (discard_d != '0)) state_d = S_FLUSH;
            S_FLUSH: if (discard_q == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model plus a program-order model of
// which pc must be fetched and delivered next, with directed boot/backpressure/redirect cases.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        dobranch = 1'b0;
    logic        dojump = 1'b0;

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .dobranch    (dobranch),
        .dojump      (dojump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] acc_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_fetch, exp_pc, prev_pc;
    logic [31:0] post_redir_pc, post_redir_acc, wrap_next;
    logic        post_pc_pend, post_acc_pend, after_taken, last_taken, seen_prev;
    int          first_acc_cyc, first_vld_cyc;
    int          ready_pct = 100, ir_pct = 100, fixed_lat = 1;
    logic        rand_redir = 1'b0;
    logic        br_en = 1'b0, jp_en = 1'b0;
    logic [31:0] br_at, jp_at;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Program image: a few hand-placed control-flow words, hashed filler elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0040_0004: mem_word = 32'h1000_0003;
            32'h0040_0008: mem_word = 32'h0810_0010;
            32'h0040_000C: mem_word = 32'h0800_0000;
            32'h0000_0000: mem_word = 32'h1000_FFFE;
            default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        endcase
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                            input logic br, input logic jp);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        if (jp)      next_pc = {pc4[31:28], w[25:0], 2'b00};
        else if (br) next_pc = pc4 + ({{16{w[15]}}, w[15:0]} << 2);
        else         next_pc = pc4;
    endfunction

    function automatic logic pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        imem_ready = 0; imem_rvalid = 0; instr_ready = 0; dobranch = 0; dojump = 0;
        mq.delete(); acc_log.delete();
        exp_fetch = RESET_PC; exp_pc = RESET_PC;
        post_pc_pend = 0; post_acc_pend = 0; after_taken = 0; last_taken = 0; seen_prev = 0;
        post_redir_pc = 32'hDEAD_BEEF; post_redir_acc = 32'hDEAD_BEEF; wrap_next = 32'hDEAD_BEEF;
        first_acc_cyc = -1; first_vld_cyc = -1;
        br_en = 0; jp_en = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic cycle();
        logic acc, hs, rv, tk;
        int   lat;
        @(negedge clk);
        cyc++;
        if (after_taken) check("valid_after_redirect", {31'd0, instr_valid}, 32'd0);
        after_taken = 0;
        last_taken = 0;
        if (instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;

        imem_ready  = pct(ready_pct);
        rv          = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mq[0].addr) : $urandom;
        instr_ready = pct(ir_pct);
        dobranch    = rand_redir ? ($urandom_range(0, 9) == 0) : 1'b0;
        dojump      = rand_redir ? ($urandom_range(0, 19) == 0) : 1'b0;
        if (instr_valid && instr_ready) begin
            if (br_en && exp_pc == br_at) begin dobranch = 1; br_en = 0; end
            if (jp_en && exp_pc == jp_at) begin dojump = 1; jp_en = 0; end
        end

        acc = imem_req && imem_ready;
        hs  = instr_valid && instr_ready;
        if (rv) void'(mq.pop_front());
        if (acc) begin
            check("imem_addr", imem_addr, exp_fetch);
            lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            mq.push_back('{addr: imem_addr, due: cyc + lat});
            acc_log.push_back(imem_addr);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (post_acc_pend) begin post_redir_acc = imem_addr; post_acc_pend = 0; end
            exp_fetch = exp_fetch + 32'd4;
        end
        if (hs) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, mem_word(exp_pc));
            if (post_pc_pend) begin post_redir_pc = instr_pc; post_pc_pend = 0; end
            if (seen_prev && prev_pc == 32'hFFFF_FFFC) wrap_next = instr_pc;
            prev_pc = exp_pc; seen_prev = 1;
            tk = dobranch || dojump;
            exp_pc = next_pc(exp_pc, mem_word(exp_pc), dobranch, dojump);
            if (tk) begin
                exp_fetch = exp_pc;
                after_taken = 1; last_taken = 1;
                post_pc_pend = 1; post_acc_pend = 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int waited;
        @(negedge clk);
        do_reset();

        // Boot: back-to-back fetch and first-word latency
        ready_pct = 100; ir_pct = 100; fixed_lat = 1;
        run(12);
        check("boot_addr0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0040_0000);
        check("boot_addr1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, 32'h0040_0004);
        check("boot_addr2", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF, 32'h0040_0008);
        check("boot_latency", 32'(first_vld_cyc - first_acc_cyc), 32'd2);

        // Backpressure: at most two words held, then released in order
        do_reset();
        ir_pct = 0;
        run(10);
        check("bp_accepts", 32'(acc_log.size()), 32'd2);
        check("bp_req_low", {31'd0, imem_req}, 32'd0);
        check("bp_valid", {31'd0, instr_valid}, 32'd1);
        check("bp_head_pc", instr_pc, RESET_PC);
        ir_pct = 100;
        run(10);

        // Branch at 0x00400004 with words already in flight
        do_reset();
        fixed_lat = 2; br_en = 1; br_at = 32'h0040_0004;
        run(20);
        check("branch_next_pc", post_redir_pc, 32'h0040_0014);

        // Jump at 0x00400008
        do_reset();
        fixed_lat = 1; jp_en = 1; jp_at = 32'h0040_0008;
        run(20);
        check("jump_next_addr", post_redir_acc, 32'h0040_0040);

        // Both asserted: jump wins
        do_reset();
        br_en = 1; br_at = 32'h0040_0008; jp_en = 1; jp_at = 32'h0040_0008;
        run(20);
        check("both_next_pc", post_redir_pc, 32'h0040_0040);

        // Reset while flushing
        do_reset();
        fixed_lat = 3; br_en = 1; br_at = 32'h0040_0004;
        waited = 0;
        while (!last_taken && waited < 60) begin cycle(); waited++; end
        check("flush_redirect_seen", {31'd0, last_taken}, 32'd1);
        cycle();
        do_reset();
        fixed_lat = 1;
        run(10);
        check("post_reset_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RESET_PC);

        // PC wrap: j 0 -> beq -2 -> 0xFFFFFFFC -> 0x00000000
        do_reset();
        jp_en = 1; jp_at = 32'h0040_000C; br_en = 1; br_at = 32'h0000_0000;
        run(40);
        check("wrap_next_pc", wrap_next, 32'h0000_0000);

        // Random traffic with random redirects and occasional resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            ready_pct = 60; ir_pct = 70; fixed_lat = 0; rand_redir = 1;
            run(1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
